nzr_waveform_gen: RTL and testbench



---
 rtl/nzr_pkg.sv | 39 +++
 rtl/nzr_period_counter.sv | 42 ++++
 rtl/nzr_waveform_gen.sv | 126 ++++++++++++
 tb/tb_nzr_waveform_gen.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nzr_pkg.sv
// Shared definitions for the NZR serial-line encoder: qmode encodings,
// default WS2812B timing at 100 MHz, counter width and the high-time lookup.
`timescale 1ns/1ps
package nzr_pkg;

    // Period counter width; bit periods up to 256 clocks fit.
    localparam int unsigned PCNT_W = 8;

    // Default timing in clocks at 100 MHz.
    localparam int unsigned NZR_CLK_PER_BIT = 128;
    localparam int unsigned NZR_T0H         = 40;
    localparam int unsigned NZR_T1H         = 80;

    // Per-bit request encodings from the GRB state machine (2'b11 acts as reset).
    localparam logic [1:0] QM_ZERO  = 2'b00;
    localparam logic [1:0] QM_ONE   = 2'b01;
    localparam logic [1:0] QM_RESET = 2'b10;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } nzr_state_e;

    // High time for a bit request; reset/illegal requests produce no high time.
    function automatic logic [PCNT_W-1:0] high_time(
        input logic [1:0]        qm,
        input logic [PCNT_W-1:0] t0h,
        input logic [PCNT_W-1:0] t1h
    );
        logic [PCNT_W-1:0] th;
        case (qm)
            QM_ZERO: th = t0h;
            QM_ONE:  th = t1h;
            default: th = {PCNT_W{1'b0}};
        endcase
        return th;
    endfunction

endpackage

// File: rtl/nzr_period_counter.sv
// Wrapping bit-period counter 0..CLK_PER_BIT-1 with synchronous clear and
// enable. tc flags the last clock of the period.
`timescale 1ns/1ps
module nzr_period_counter
    import nzr_pkg::*;
#(
    parameter int unsigned CLK_PER_BIT = NZR_CLK_PER_BIT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              en,
    output logic [PCNT_W-1:0] pcnt,
    output logic              tc
);

    localparam logic [PCNT_W-1:0] LAST_CNT = PCNT_W'(CLK_PER_BIT - 1);
    localparam logic [PCNT_W-1:0] CNT_ONE  = {{(PCNT_W-1){1'b0}}, 1'b1};

    logic [PCNT_W-1:0] pcnt_r;

    assign pcnt = pcnt_r;
    assign tc   = (pcnt_r == LAST_CNT);

    // Period counter: clear has priority, otherwise count and wrap at the last clock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pcnt_r <= {PCNT_W{1'b0}};
        end else if (clr) begin
            pcnt_r <= {PCNT_W{1'b0}};
        end else if (en) begin
            if (tc) begin
                pcnt_r <= {PCNT_W{1'b0}};
            end else begin
                pcnt_r <= pcnt_r + CNT_ONE;
            end
        end else begin
            pcnt_r <= pcnt_r;
        end
    end

endmodule

// File: rtl/nzr_waveform_gen.sv
// NZR waveform generator for a WS2812B chain. Turns the per-bit qmode request
// into a fixed-period high/low pulse and returns bdone in the last clock of
// each bit period. Legal timing: 0 < T0H < T1H < CLK_PER_BIT <= 256.
`timescale 1ns/1ps
module nzr_waveform_gen
    import nzr_pkg::*;
#(
    parameter int unsigned CLK_PER_BIT = NZR_CLK_PER_BIT,
    parameter int unsigned T0H         = NZR_T0H,
    parameter int unsigned T1H         = NZR_T1H
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       StartCoding,
    input  logic [1:0] qmode,
    output logic       bdone,
    output logic       dout,
    output logic       busy
);

    localparam logic [PCNT_W-1:0] T0H_C = PCNT_W'(T0H);
    localparam logic [PCNT_W-1:0] T1H_C = PCNT_W'(T1H);

    nzr_state_e        state_r;
    nzr_state_e        state_next_s;
    logic [1:0]        mode_q_r;
    logic              dout_r;
    logic              dout_next_s;
    logic [PCNT_W-1:0] thigh_s;
    logic [PCNT_W-1:0] pcnt_s;
    logic              tc_s;
    logic              cnt_clr_s;
    logic              active_s;
    logic              at_zero_s;

    assign active_s  = (state_r == ST_ACTIVE);
    assign at_zero_s = (pcnt_s == {PCNT_W{1'b0}});

    nzr_period_counter #(
        .CLK_PER_BIT (CLK_PER_BIT)
    ) u_pcnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr_s),
        .en    (active_s),
        .pcnt  (pcnt_s),
        .tc    (tc_s)
    );

    // Next state: start/restart enters ACTIVE; a reset request at pcnt 0 ends the frame.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (StartCoding) begin
                    state_next_s = ST_ACTIVE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (StartCoding) begin
                    state_next_s = ST_ACTIVE;
                end else if (at_zero_s && qmode[1]) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_ACTIVE;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Counter clear, high-time select and waveform compare.
    always_comb begin
        cnt_clr_s   = StartCoding || (state_next_s == ST_IDLE);
        thigh_s     = {PCNT_W{1'b0}};
        dout_next_s = 1'b0;
        // At pcnt 0 mode_q is not yet loaded, so the live request sets the high time.
        if (at_zero_s) begin
            thigh_s = high_time(qmode, T0H_C, T1H_C);
        end else begin
            thigh_s = high_time(mode_q_r, T0H_C, T1H_C);
        end
        // A restart forces one low clock so the truncated bit ends with a clean edge.
        if (active_s && !StartCoding) begin
            dout_next_s = (pcnt_s < thigh_s);
        end else begin
            dout_next_s = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Capture the data-bit request at the start of each bit period.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_q_r <= QM_ZERO;
        end else if (active_s && at_zero_s && !qmode[1]) begin
            mode_q_r <= qmode;
        end else begin
            mode_q_r <= mode_q_r;
        end
    end

    // Output register for the serial line.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dout_r <= 1'b0;
        end else begin
            dout_r <= dout_next_s;
        end
    end

    assign dout  = dout_r;
    assign busy  = active_s;
    assign bdone = active_s && tc_s;

endmodule

// File: tb/tb_nzr_waveform_gen.sv
// Scoreboard bench for nzr_waveform_gen: stimulus pushes expected high pulses
// (start cycle, width) and bdone cycles; a monitor pops and compares.
`timescale 1ns/1ps
module tb_nzr_waveform_gen;

    localparam int K_PULSE = 0;
    localparam int K_BDONE = 1;

    typedef struct {
        int inst;
        int kind;
        int cyc;
        int width;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] sc_v = 2'b00;
    logic [1:0] qm0 = 2'b10;
    logic [1:0] qm1 = 2'b10;
    logic [1:0] dout_v;
    logic [1:0] bdone_v;
    logic [1:0] busy_v;

    int  total = 0;
    int  bad   = 0;
    int  cyc   = 0;
    ev_t exp_q[$];
    int  run_len[2];
    int  run_start[2];

    nzr_waveform_gen dut0 (
        .clk         (clk),
        .reset       (reset),
        .StartCoding (sc_v[0]),
        .qmode       (qm0),
        .bdone       (bdone_v[0]),
        .dout        (dout_v[0]),
        .busy        (busy_v[0])
    );

    nzr_waveform_gen #(.CLK_PER_BIT(16), .T0H(4), .T1H(10)) dut1 (
        .clk         (clk),
        .reset       (reset),
        .StartCoding (sc_v[1]),
        .qmode       (qm1),
        .bdone       (bdone_v[1]),
        .dout        (dout_v[1]),
        .busy        (busy_v[1])
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_ev(input int inst, input int kind, input int c, input int w);
        ev_t e;
        e.inst = inst; e.kind = kind; e.cyc = c; e.width = w;
        exp_q.push_back(e);
    endtask

    task automatic check_event(input int inst, input int kind, input int c, input int w);
        ev_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event: inst=%0d kind=%0d cycle=%0d width=%0d, none expected",
                     inst, kind, c, w);
        end else begin
            e = exp_q.pop_front();
            if (e.inst != inst || e.kind != kind || e.cyc != c || e.width != w) begin
                bad++;
                $display("FAIL event: got inst=%0d kind=%0d cycle=%0d width=%0d expected inst=%0d kind=%0d cycle=%0d width=%0d",
                         inst, kind, c, w, e.inst, e.kind, e.cyc, e.width);
            end
        end
    endtask

    // Monitor: measures each dout high run and each bdone pulse.
    initial begin
        run_len[0] = 0; run_len[1] = 0;
        run_start[0] = 0; run_start[1] = 0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (dout_v[i] === 1'b1) begin
                    if (run_len[i] == 0) run_start[i] = cyc;
                    run_len[i]++;
                end else if (run_len[i] > 0) begin
                    check_event(i, K_PULSE, run_start[i], run_len[i]);
                    run_len[i] = 0;
                end
                if (bdone_v[i] === 1'b1) check_event(i, K_BDONE, cyc, 0);
            end
        end
    end

    task automatic set_sc(input int inst, input logic v);
        if (inst == 0) sc_v[0] = v; else sc_v[1] = v;
    endtask

    task automatic set_qm(input int inst, input logic [1:0] v);
        if (inst == 0) qm0 = v; else qm1 = v;
    endtask

    // Pulse StartCoding in cycle t with the given request; returns t, ends in cycle t+1.
    task automatic start_bit(input int inst, input logic [1:0] qm, output int t);
        @(posedge clk); #1;
        t = cyc;
        set_qm(inst, qm);
        set_sc(inst, 1'b1);
        @(posedge clk); #1;
        set_sc(inst, 1'b0);
    endtask

    // Bit started in cycle t0: high from t0+2 for th clocks, bdone at t0+per.
    task automatic expect_bit(input int inst, input int t0, input int th, input int per);
        if (th > 0) push_ev(inst, K_PULSE, t0 + 2, th);
        push_ev(inst, K_BDONE, t0 + per, 0);
    endtask

    // Wait for bdone, then step into the following cycle as upstream would.
    task automatic wait_bdone(input int inst, input int limit);
        bit got;
        got = 1'b0;
        for (int k = 0; k < limit; k++) begin
            @(negedge clk);
            if (bdone_v[inst] === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL bdone_timeout: inst=%0d no bdone within %0d cycles", inst, limit);
        end
        @(posedge clk); #1;
    endtask

    // Present the reset request after the last bdone; busy drops one cycle later.
    task automatic end_frame(input int inst);
        set_qm(inst, 2'b10);
        @(negedge clk);
        chk("busy_at_stop_sample", busy_v[inst], 1);
        @(negedge clk);
        chk("busy_dropped", busy_v[inst], 0);
        chk("dout_low_after_frame", dout_v[inst], 0);
    endtask

    // Model of the GRB state machine: MSB first, next bit offered after each bdone.
    task automatic send_frame(input int inst, input logic [31:0] pat, input int n,
                              input int per, input int t0h, input int t1h);
        int t;
        start_bit(inst, {1'b0, pat[n-1]}, t);
        for (int i = 0; i < n; i++) begin
            expect_bit(inst, t + i * per, (pat[n-1-i] == 1'b1) ? t1h : t0h, per);
        end
        for (int i = 0; i < n; i++) begin
            wait_bdone(inst, per + 8);
            if (i < n - 1) set_qm(inst, {1'b0, pat[n-2-i]});
        end
        end_frame(inst);
    endtask

    initial begin
        int t;
        int t2;
        int nz;

        // Reset state.
        #1 reset = 1'b0;
        #2;
        chk("rst_dout0", dout_v[0], 0);
        chk("rst_bdone0", bdone_v[0], 0);
        chk("rst_busy0", busy_v[0], 0);
        chk("rst_dout1", dout_v[1], 0);
        chk("rst_bdone1", bdone_v[1], 0);
        chk("rst_busy1", busy_v[1], 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        repeat (4) @(posedge clk);

        // Single 0 bit: 40-clock high from t+2, bdone t+128, busy low t+130.
        send_frame(0, 32'h0000_0000, 1, 128, 40, 80);
        repeat (20) @(posedge clk);

        // 24-bit frame 0xA5A5A5.
        send_frame(0, 32'h00A5_A5A5, 24, 128, 40, 80);
        repeat (20) @(posedge clk);

        // Illegal request at the first sample: one busy cycle, nothing emitted.
        start_bit(0, 2'b11, t);
        @(negedge clk);
        chk("illegal_busy_one_cycle", busy_v[0], 1);
        @(negedge clk);
        chk("illegal_busy_dropped", busy_v[0], 0);
        set_qm(0, 2'b10);
        repeat (150) @(posedge clk);

        // Restart at pcnt 60 of a 1 bit: first pulse cut to 60, one low clock, fresh bit.
        start_bit(0, 2'b01, t);
        push_ev(0, K_PULSE, t + 2, 60);
        repeat (60) @(posedge clk);
        #1;
        t2 = cyc;
        set_sc(0, 1'b1);
        @(posedge clk); #1;
        set_sc(0, 1'b0);
        expect_bit(0, t2, 80, 128);
        @(negedge clk);
        chk("restart_low_gap", dout_v[0], 0);
        wait_bdone(0, 140);
        end_frame(0);
        repeat (20) @(posedge clk);

        // Asynchronous reset at pcnt 20 of a 1 bit.
        start_bit(0, 2'b01, t);
        push_ev(0, K_PULSE, t + 2, 19);
        repeat (20) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_dout", dout_v[0], 0);
        chk("async_rst_bdone", bdone_v[0], 0);
        chk("async_rst_busy", busy_v[0], 0);
        set_qm(0, 2'b10);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        nz = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (dout_v[0] !== 1'b0 || bdone_v[0] !== 1'b0 || busy_v[0] !== 1'b0) nz++;
        end
        chk("quiet_after_reset", nz, 0);

        // Overridden timing: period 16, highs 4 and 10.
        send_frame(1, 32'h0000_0002, 3, 16, 4, 10);
        repeat (40) @(posedge clk);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
